sram_wrapper: RTL and testbench

AXI4 slave wrapper that consumes the read/write transactions issued by the CPU-side master wrapper and drives one single-port word SRAM macro (instruction or data memory). Serves one transaction at a time, supports INCR bursts up to 16 beats, and keeps every AXI output stable under back-pressure.

---
 rtl/sram_wrapper_if.sv | 57 +++++
 rtl/sram_wrapper.sv | 193 +++++++++++++++++++
 tb/tb_sram_wrapper.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_wrapper_if.sv
// AXI4 slave-side bus seen by sram_wrapper: AR/R/AW/W/B channels with ID_W-wide IDs.
// The slave modport is used by the wrapper, and the master modport by whatever issues the bursts.
interface sram_wrapper_if #(
    parameter int ID_W = 8
);
    logic [ID_W-1:0] ARID_S;
    logic [31:0]     ARADDR_S;
    logic [3:0]      ARLEN_S;
    logic            ARVALID_S;
    logic            ARREADY_S;
    logic [ID_W-1:0] RID_S;
    logic [31:0]     RDATA_S;
    logic [1:0]      RRESP_S;
    logic            RLAST_S;
    logic            RVALID_S;
    logic            RREADY_S;
    logic [ID_W-1:0] AWID_S;
    logic [31:0]     AWADDR_S;
    logic [3:0]      AWLEN_S;
    logic            AWVALID_S;
    logic            AWREADY_S;
    logic [31:0]     WDATA_S;
    logic [3:0]      WSTRB_S;
    logic            WLAST_S;
    logic            WVALID_S;
    logic            WREADY_S;
    logic [ID_W-1:0] BID_S;
    logic [1:0]      BRESP_S;
    logic            BVALID_S;
    logic            BREADY_S;

    modport slave (
        input  ARID_S, ARADDR_S, ARLEN_S, ARVALID_S,
        output ARREADY_S,
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S,
        input  AWID_S, AWADDR_S, AWLEN_S, AWVALID_S,
        output AWREADY_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        output WREADY_S,
        output BID_S, BRESP_S, BVALID_S,
        input  BREADY_S
    );

    modport master (
        output ARID_S, ARADDR_S, ARLEN_S, ARVALID_S,
        input  ARREADY_S,
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S,
        output AWID_S, AWADDR_S, AWLEN_S, AWVALID_S,
        input  AWREADY_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        input  WREADY_S,
        input  BID_S, BRESP_S, BVALID_S,
        output BREADY_S
    );
endinterface

// File: rtl/sram_wrapper.sv
// AXI4 slave serving one INCR burst (up to 16 beats) at a time from a single-port word SRAM.
// Optional feature SRAM_WRAPPER_RESP_CHECK_EN: SLVERR on a WLAST mismatch and on reads with ARADDR_S[31:16] != 0.
module sram_wrapper #(
    parameter int ID_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    sram_wrapper_if.slave bus,
    output logic          sram_cs,
    output logic          sram_oe,
    output logic [3:0]    sram_web,
    output logic [13:0]   sram_a,
    output logic [31:0]   sram_di,
    input  logic [31:0]   sram_do
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_R_ACC,
        S_R_DATA,
        S_W_DATA,
        S_W_RESP
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_id;
    logic [13:0]     r_addr;
    logic [3:0]      r_len;
    logic [3:0]      r_cnt;
    logic [31:0]     r_rdata;
    logic            r_fresh;
`ifdef SRAM_WRAPPER_RESP_CHECK_EN
    logic            r_err;
`endif

    logic w_ar_hs;
    logic w_aw_hs;
    logic w_r_hs;
    logic w_w_hs;
    logic w_last_beat;
    logic w_unused;

    // Masked during reset so that every AXI output reads 0 while rst is high.
    assign bus.AWREADY_S = !rst && (r_state == S_IDLE);
    assign bus.ARREADY_S = !rst && (r_state == S_IDLE) && !bus.AWVALID_S;

    assign w_aw_hs     = bus.AWVALID_S && bus.AWREADY_S;
    assign w_ar_hs     = bus.ARVALID_S && bus.ARREADY_S;
    assign w_r_hs      = bus.RVALID_S && bus.RREADY_S;
    assign w_w_hs      = bus.WVALID_S && bus.WREADY_S;
    assign w_last_beat = (r_cnt == r_len);

`ifdef SRAM_WRAPPER_RESP_CHECK_EN
    assign w_unused = ^{bus.ARADDR_S[1:0], bus.AWADDR_S[31:16], bus.AWADDR_S[1:0]};
`else
    assign w_unused = ^{bus.ARADDR_S[31:16], bus.ARADDR_S[1:0], bus.AWADDR_S[31:16],
                        bus.AWADDR_S[1:0], bus.WLAST_S};
`endif

    // NOTE: state is updated with non-blocking assignments so that every register samples
    // pre-edge values; the reset branch is asynchronous, so it can abort a burst at any time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_fresh <= 1'b0;
`ifdef SRAM_WRAPPER_RESP_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_aw_hs) begin
                        r_id    <= bus.AWID_S;
                        r_addr  <= bus.AWADDR_S[15:2];
                        r_len   <= bus.AWLEN_S;
                        r_state <= S_W_DATA;
`ifdef SRAM_WRAPPER_RESP_CHECK_EN
                        r_err   <= 1'b0;
`endif
                    end else if (w_ar_hs) begin
                        r_id    <= bus.ARID_S;
                        r_addr  <= bus.ARADDR_S[15:2];
                        r_len   <= bus.ARLEN_S;
                        r_state <= S_R_ACC;
`ifdef SRAM_WRAPPER_RESP_CHECK_EN
                        r_err   <= |bus.ARADDR_S[31:16];
`endif
                    end
                end
                S_R_ACC: begin
                    r_fresh <= 1'b1;
                    r_state <= S_R_DATA;
                end
                S_R_DATA: begin
                    // The SRAM output is only guaranteed in the first cycle; hold it for back-pressure.
                    if (r_fresh) begin
                        r_rdata <= sram_do;
                        r_fresh <= 1'b0;
                    end
                    if (w_r_hs) begin
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_addr  <= r_addr + 14'd1;
                            r_cnt   <= r_cnt + 4'd1;
                            r_state <= S_R_ACC;
                        end
                    end
                end
                S_W_DATA: begin
                    if (w_w_hs) begin
                        r_addr <= r_addr + 14'd1;
                        r_cnt  <= r_cnt + 4'd1;
`ifdef SRAM_WRAPPER_RESP_CHECK_EN
                        r_err  <= r_err | (bus.WLAST_S != w_last_beat);
`endif
                        if (w_last_beat) begin
                            r_state <= S_W_RESP;
                        end
                    end
                end
                S_W_RESP: begin
                    if (bus.BREADY_S) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        sram_cs      = 1'b0;
        sram_oe      = 1'b0;
        sram_web     = 4'hF;
        sram_a       = r_addr;
        sram_di      = '0;
        bus.RID_S    = r_id;
        bus.RDATA_S  = '0;
        bus.RRESP_S  = 2'b00;
        bus.RLAST_S  = 1'b0;
        bus.RVALID_S = 1'b0;
        bus.WREADY_S = 1'b0;
        bus.BID_S    = r_id;
        bus.BRESP_S  = 2'b00;
        bus.BVALID_S = 1'b0;
        case (r_state)
            S_R_ACC: begin
`ifdef SRAM_WRAPPER_RESP_CHECK_EN
                sram_cs = !r_err;
                sram_oe = !r_err;
`else
                sram_cs = 1'b1;
                sram_oe = 1'b1;
`endif
            end
            S_R_DATA: begin
                bus.RVALID_S = 1'b1;
                bus.RLAST_S  = w_last_beat;
                bus.RDATA_S  = r_fresh ? sram_do : r_rdata;
`ifdef SRAM_WRAPPER_RESP_CHECK_EN
                if (r_err) begin
                    bus.RDATA_S = '0;
                    bus.RRESP_S = 2'b10;
                end
`endif
            end
            S_W_DATA: begin
                bus.WREADY_S = 1'b1;
                sram_cs      = 1'b1;
                sram_di      = bus.WDATA_S;
                if (bus.WVALID_S) begin
                    sram_web = ~bus.WSTRB_S;
                end
            end
            S_W_RESP: begin
                bus.BVALID_S = 1'b1;
`ifdef SRAM_WRAPPER_RESP_CHECK_EN
                bus.BRESP_S  = r_err ? 2'b10 : 2'b00;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_wrapper.sv
// Self-checking bench for sram_wrapper: an SRAM macro model, a reference memory and R/B scoreboards.
// Built with SRAM_WRAPPER_RESP_CHECK_EN undefined, so every response is expected to be OKAY.
`timescale 1ns/1ps
module tb_sram_wrapper;
    localparam int ID_W = 8;
    localparam int TMO  = 50;

    typedef struct packed {
        logic [31:0]     data;
        logic            last;
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } r_exp_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_cs;
    logic        sram_oe;
    logic [3:0]  sram_web;
    logic [13:0] sram_a;
    logic [31:0] sram_di;
    logic [31:0] sram_do;

    logic        bd_we;
    logic [13:0] bd_a;
    logic [31:0] bd_d;

    logic [31:0] mem     [0:16383];
    logic [31:0] exp_mem [0:16383];
    r_exp_t      r_q[$];
    b_exp_t      b_q[$];
    int          check_cnt = 0;
    int          err_cnt   = 0;

    always #5 clk = ~clk;

    sram_wrapper_if #(.ID_W(ID_W)) bus ();

    sram_wrapper #(.ID_W(ID_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sram_cs  (sram_cs),
        .sram_oe  (sram_oe),
        .sram_web (sram_web),
        .sram_a   (sram_a),
        .sram_di  (sram_di),
        .sram_do  (sram_do)
    );

    // NOTE: the macro model is deliberately not reset; a real SRAM powers up with unknown contents.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_a] <= bd_d;
        end else if (sram_cs) begin
            if (sram_oe) sram_do <= mem[sram_a];
            for (int b = 0; b < 4; b++) begin
                if (!sram_web[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
            end
        end
    end

    task automatic init_inputs();
        bus.ARID_S = '0;   bus.ARADDR_S = '0; bus.ARLEN_S = '0; bus.ARVALID_S = 1'b0;
        bus.RREADY_S = 1'b0;
        bus.AWID_S = '0;   bus.AWADDR_S = '0; bus.AWLEN_S = '0; bus.AWVALID_S = 1'b0;
        bus.WDATA_S = '0;  bus.WSTRB_S = '0;  bus.WLAST_S = 1'b0; bus.WVALID_S = 1'b0;
        bus.BREADY_S = 1'b0;
        bd_we = 1'b0; bd_a = '0; bd_d = '0;
    endtask

    task automatic preload(input logic [13:0] w, input logic [31:0] d);
        @(posedge clk); #1;
        bd_we = 1'b1; bd_a = w; bd_d = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
        exp_mem[w] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_cnt++;
        if ({bus.ARREADY_S, bus.AWREADY_S, bus.RVALID_S, bus.RLAST_S, bus.WREADY_S, bus.BVALID_S} !== 6'b0) begin
            err_cnt++;
            $display("FAIL %s_ctrl: got %b expected 000000", tag,
                     {bus.ARREADY_S, bus.AWREADY_S, bus.RVALID_S, bus.RLAST_S, bus.WREADY_S, bus.BVALID_S});
        end
        check_cnt++;
        if ({bus.RDATA_S, bus.RID_S, bus.RRESP_S, bus.BID_S, bus.BRESP_S} !== '0) begin
            err_cnt++;
            $display("FAIL %s_data: got rdata=%h rid=%h rresp=%b bid=%h bresp=%b expected all 0", tag,
                     bus.RDATA_S, bus.RID_S, bus.RRESP_S, bus.BID_S, bus.BRESP_S);
        end
        check_cnt++;
        if ({sram_cs, sram_oe, sram_web, sram_a, sram_di} !== {1'b0, 1'b0, 4'hF, 14'd0, 32'd0}) begin
            err_cnt++;
            $display("FAIL %s_sram: got cs=%b oe=%b web=%h a=%h di=%h expected 0 0 f 0 0", tag,
                     sram_cs, sram_oe, sram_web, sram_a, sram_di);
        end
    endtask

    task automatic aw_phase(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
        int n;
        bus.AWVALID_S = 1'b1; bus.AWADDR_S = addr; bus.AWLEN_S = len; bus.AWID_S = id;
        b_q.push_back('{id: id, resp: 2'b00});
        n = 0;
        @(negedge clk);
        while (!bus.AWREADY_S && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin
            check_cnt++; err_cnt++;
            $display("FAIL aw_timeout: got no AWREADY_S within %0d cycles, required 1", TMO);
        end
        @(posedge clk); #1;
        bus.AWVALID_S = 1'b0;
    endtask

    task automatic w_phase(input logic [13:0] word, input logic [3:0] len,
                           input logic [31:0] d [16], input logic [3:0] strb);
        int n;
        logic [13:0] w;
        for (int i = 0; i <= int'(len); i++) begin
            bus.WVALID_S = 1'b1; bus.WDATA_S = d[i]; bus.WSTRB_S = strb;
            bus.WLAST_S  = (i == int'(len));
            n = 0;
            @(negedge clk);
            while (!bus.WREADY_S && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) begin
                check_cnt++; err_cnt++;
                $display("FAIL w_timeout: beat %0d got no WREADY_S, required 1", i);
            end
            w = word + 14'(i);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) exp_mem[w][8*b +: 8] = d[i][8*b +: 8];
            end
            @(posedge clk); #1;
        end
        bus.WVALID_S = 1'b0; bus.WLAST_S = 1'b0;
    endtask

    task automatic b_phase(input int delay);
        int n;
        b_exp_t e;
        bus.BREADY_S = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.BVALID_S && n < TMO) begin @(posedge clk); @(negedge clk); n++; end
        e = (b_q.size() > 0) ? b_q.pop_front() : '0;
        repeat (delay) begin
            check_cnt++;
            if ({bus.BVALID_S, bus.BID_S, bus.BRESP_S} !== {1'b1, e.id, e.resp}) begin
                err_cnt++;
                $display("FAIL b_hold: got valid=%b id=%h resp=%b required 1 %h %b",
                         bus.BVALID_S, bus.BID_S, bus.BRESP_S, e.id, e.resp);
            end
            @(posedge clk); @(negedge clk);
        end
        bus.BREADY_S = 1'b1;
        check_cnt++;
        if ({bus.BVALID_S, bus.BID_S, bus.BRESP_S} !== {1'b1, e.id, e.resp}) begin
            err_cnt++;
            $display("FAIL b_resp: got valid=%b id=%h resp=%b required 1 %h %b",
                     bus.BVALID_S, bus.BID_S, bus.BRESP_S, e.id, e.resp);
        end
        @(posedge clk); #1;
        bus.BREADY_S = 1'b0;
        check_cnt++;
        if (bus.BVALID_S !== 1'b0) begin
            err_cnt++;
            $display("FAIL b_single: got BVALID_S=%b after handshake, required 0", bus.BVALID_S);
        end
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
        int n;
        logic [13:0] w;
        bus.ARVALID_S = 1'b1; bus.ARADDR_S = addr; bus.ARLEN_S = len; bus.ARID_S = id;
        n = 0;
        @(negedge clk);
        while (!bus.ARREADY_S && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin
            check_cnt++; err_cnt++;
            $display("FAIL ar_timeout: got no ARREADY_S within %0d cycles, required 1", TMO);
        end
        for (int i = 0; i <= int'(len); i++) begin
            w = addr[15:2] + 14'(i);
            r_q.push_back('{data: exp_mem[w], last: (i == int'(len)), id: id, resp: 2'b00});
        end
        @(posedge clk); #1;
        bus.ARVALID_S = 1'b0;
    endtask

    task automatic r_phase(input logic [3:0] len, input int stall_beat);
        int n;
        r_exp_t e;
        bus.RREADY_S = (stall_beat != 0);
        @(negedge clk);
        check_cnt++;
        if (bus.RVALID_S !== 1'b0) begin
            err_cnt++;
            $display("FAIL r_latency_acc: got RVALID_S=%b one cycle after AR, required 0", bus.RVALID_S);
        end
        @(posedge clk); @(negedge clk);
        check_cnt++;
        if (bus.RVALID_S !== 1'b1) begin
            err_cnt++;
            $display("FAIL r_latency_data: got RVALID_S=%b two cycles after AR, required 1", bus.RVALID_S);
        end
        for (int i = 0; i <= int'(len); i++) begin
            bus.RREADY_S = (i != stall_beat);
            if (i > 0) @(negedge clk);
            n = 0;
            while (!bus.RVALID_S && n < TMO) begin @(posedge clk); @(negedge clk); n++; end
            if (n >= TMO) begin
                check_cnt++; err_cnt++;
                $display("FAIL r_timeout: beat %0d got no RVALID_S, required 1", i);
            end
            e = (r_q.size() > 0) ? r_q.pop_front() : '0;
            if (i == stall_beat) begin
                repeat (5) begin
                    check_cnt++;
                    if ({bus.RVALID_S, bus.RDATA_S, bus.RLAST_S} !== {1'b1, e.data, e.last}) begin
                        err_cnt++;
                        $display("FAIL r_hold: got valid=%b data=%h last=%b required 1 %h %b",
                                 bus.RVALID_S, bus.RDATA_S, bus.RLAST_S, e.data, e.last);
                    end
                    @(posedge clk); @(negedge clk);
                end
                bus.RREADY_S = 1'b1;
            end
            check_cnt++;
            if ({bus.RDATA_S, bus.RLAST_S, bus.RID_S, bus.RRESP_S} !== {e.data, e.last, e.id, e.resp}) begin
                err_cnt++;
                $display("FAIL r_beat%0d: got data=%h last=%b id=%h resp=%b required %h %b %h %b", i,
                         bus.RDATA_S, bus.RLAST_S, bus.RID_S, bus.RRESP_S, e.data, e.last, e.id, e.resp);
            end
            @(posedge clk); #1;
        end
        bus.RREADY_S = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_cnt++;
        if ({bus.ARREADY_S, bus.AWREADY_S} !== 2'b11) begin
            err_cnt++;
            $display("FAIL idle_ready: got %b required 11", {bus.ARREADY_S, bus.AWREADY_S});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        preload(14'h10, 32'hDEADBEEF);
        ar_phase(32'h40, 4'd0, 8'h05);
        r_phase(4'd0, -1);
    endtask

    task automatic test_burst();
        logic [31:0] d [16];
        for (int i = 0; i < 16; i++) d[i] = 32'(i + 1);
        aw_phase(32'h0, 4'd3, 8'h01);
        w_phase(14'h0, 4'd3, d, 4'hF);
        b_phase(0);
        ar_phase(32'h0, 4'd3, 8'h02);
        r_phase(4'd3, -1);
    endtask

    task automatic test_strobe();
        logic [31:0] d [16];
        for (int i = 0; i < 16; i++) d[i] = 32'hAABBCCDD;
        preload(14'h20, 32'h11223344);
        aw_phase(32'h80, 4'd0, 8'h07);
        w_phase(14'h20, 4'd0, d, 4'b0101);
        b_phase(0);
        check_cnt++;
        if (mem[14'h20] !== 32'h11BB33DD) begin
            err_cnt++;
            $display("FAIL strobe_mem: got %h required 11bb33dd", mem[14'h20]);
        end
        ar_phase(32'h80, 4'd0, 8'h08);
        r_phase(4'd0, -1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [16];
        for (int i = 0; i < 16; i++) d[i] = 32'h5A00_0000 + 32'(i);
        bus.ARVALID_S = 1'b1; bus.ARADDR_S = 32'hC0; bus.ARLEN_S = 4'd1; bus.ARID_S = 8'h21;
        bus.AWVALID_S = 1'b1; bus.AWADDR_S = 32'hC0; bus.AWLEN_S = 4'd1; bus.AWID_S = 8'h20;
        b_q.push_back('{id: 8'h20, resp: 2'b00});
        @(negedge clk);
        check_cnt++;
        if ({bus.AWREADY_S, bus.ARREADY_S} !== 2'b10) begin
            err_cnt++;
            $display("FAIL collision_ready: got aw/ar=%b required 10", {bus.AWREADY_S, bus.ARREADY_S});
        end
        @(posedge clk); #1;
        bus.AWVALID_S = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (bus.ARREADY_S !== 1'b0) begin
            err_cnt++;
            $display("FAIL collision_ar_blocked: got ARREADY_S=%b during write, required 0", bus.ARREADY_S);
        end
        @(posedge clk); #1;
        w_phase(14'h30, 4'd1, d, 4'hF);
        b_phase(3);
        ar_phase(32'hC0, 4'd1, 8'h21);
        r_phase(4'd1, 1);
    endtask

    task automatic test_wrap();
        logic [31:0] d [16];
        for (int i = 0; i < 16; i++) d[i] = 32'hCAFE0001 + 32'(i);
        aw_phase(32'h1234_FFFC, 4'd1, 8'h0A);
        w_phase(14'h3FFF, 4'd1, d, 4'hF);
        b_phase(0);
        check_cnt++;
        if ({mem[14'h3FFF], mem[14'h0]} !== {32'hCAFE0001, 32'hCAFE0002}) begin
            err_cnt++;
            $display("FAIL wrap_mem: got %h %h required cafe0001 cafe0002", mem[14'h3FFF], mem[14'h0]);
        end
        ar_phase(32'hFFFC, 4'd1, 8'h0B);
        r_phase(4'd1, -1);
    endtask

    task automatic test_reset_mid_burst();
        ar_phase(32'h0, 4'd3, 8'h33);
        bus.RREADY_S = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        check_reset_outputs("mid_reset");
        r_q.delete();
        bus.RREADY_S = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        ar_phase(32'h80, 4'd0, 8'h44);
        r_phase(4'd0, -1);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst();
        test_strobe();
        test_back_to_back();
        test_wrap();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        check_cnt++; err_cnt++;
        $display("FAIL watchdog: got simulation still running at 200us, required completion");
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
